// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Circular-buffer queue between the fetch and decode stages.
//               Each entry carries {PC, instruction word, exception flags}.
//               Head fields read as zero whenever no valid entry is shown.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH          number of entries, power of two in 2..16 (default 4)
// Optional build macro
//   IFQ_BYPASS_EN  when defined, an empty queue shows the fetch input
//                  directly at the head in the same cycle; if decode
//                  accepts it, it is consumed and never written.
// Ports
//   Clk            clock, rising edge
//   Clr_n          asynchronous active-low reset
//   flush          synchronous discard of all entries (wins over enq/deq)
//   I_valid/I_PC/I_Instr/I_exc   fetch-side entry presented this cycle
//   q_full         count == DEPTH, fetch must stall
//   q_almost_full  count >= DEPTH-1
//   D_ready        decode accepts the head entry
//   D_valid/D_PC/D_Instr/D_exc   head entry
//   q_count        number of occupied entries
// ============================================================================
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Clr_n,
  input  logic                       flush,
  input  logic                       I_valid,
  input  logic [31:0]                I_PC,
  input  logic [31:0]                I_Instr,
  input  logic [2:0]                 I_exc,
  output logic                       q_full,
  output logic                       q_almost_full,
  input  logic                       D_ready,
  output logic                       D_valid,
  output logic [31:0]                D_PC,
  output logic [31:0]                D_Instr,
  output logic [2:0]                 D_exc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] c_DEPTH_M1 = CW'(DEPTH - 1);

  // Entry storage; deliberately not reset.
  logic [31:0] r_pc_mem    [DEPTH];
  logic [31:0] r_instr_mem [DEPTH];
  logic [2:0]  r_exc_mem   [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_DEPTH);
  assign q_full        = w_full;
  assign q_almost_full = (r_count >= c_DEPTH_M1);
  assign q_count       = r_count;

  // Dequeue only ever pops stored entries; a bypassed entry never occupies storage.
  assign w_deq = ~w_empty & D_ready & ~flush;

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  // Gated with Clr_n so the head reads invalid while reset is held.
  assign w_bypass = w_empty & I_valid & ~flush & Clr_n;
  assign w_enq    = I_valid & ~w_full & ~flush & ~(w_bypass & D_ready);
`else
  assign w_enq    = I_valid & ~w_full & ~flush;
`endif

  // Pointers and occupancy. DEPTH is a power of two, so natural
  // overflow of the PW-bit pointers gives the DEPTH-1 -> 0 wrap.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_enq) begin
      r_pc_mem[r_wptr]    <= I_PC;
      r_instr_mem[r_wptr] <= I_Instr;
      r_exc_mem[r_wptr]   <= I_exc;
    end
  end

  // Head presentation; all fields zero when nothing valid is shown.
  always_comb begin
    D_valid = 1'b0;
    D_PC    = '0;
    D_Instr = '0;
    D_exc   = '0;
    if (!w_empty) begin
      D_valid = 1'b1;
      D_PC    = r_pc_mem[r_rptr];
      D_Instr = r_instr_mem[r_rptr];
      D_exc   = r_exc_mem[r_rptr];
    end
`ifdef IFQ_BYPASS_EN
    else if (w_bypass) begin
      D_valid = 1'b1;
      D_PC    = I_PC;
      D_Instr = I_Instr;
      D_exc   = I_exc;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue (DEPTH = 4,
//               default build). Table of vectors with hand-derived occupancy
//               plus a scoreboard of expected head entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Clr_n;
  logic        flush;
  logic        I_valid;
  logic [31:0] I_PC;
  logic [31:0] I_Instr;
  logic [2:0]  I_exc;
  logic        q_full;
  logic        q_almost_full;
  logic        D_ready;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [2:0]  D_exc;
  logic [2:0]  q_count;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .flush(flush),
    .I_valid(I_valid), .I_PC(I_PC), .I_Instr(I_Instr), .I_exc(I_exc),
    .q_full(q_full), .q_almost_full(q_almost_full),
    .D_ready(D_ready), .D_valid(D_valid), .D_PC(D_PC),
    .D_Instr(D_Instr), .D_exc(D_exc), .q_count(q_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  exc;
  } entry_t;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  exc;
    logic        ready;
    int          exp_count;
    logic        exp_full;
    logic        exp_afull;
  } vec_t;

  entry_t sb[$];
  int     n_vec  = 0;
  int     n_miss = 0;
  int     n_pop  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Inputs are driven just after a rising edge;
  // head is checked on the falling edge; occupancy just after the next edge.
  // exp_count < 0 means occupancy is checked only against the scoreboard.
  task automatic step(input logic fl, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [2:0] ex, input logic rd,
                      input int exp_count, input logic exp_full, input logic exp_afull);
    logic   m_enq, m_deq;
    entry_t e;
    flush = fl; I_valid = v; I_PC = pc; I_Instr = ins; I_exc = ex; D_ready = rd;
    @(negedge Clk);
    chk("d_valid", {31'd0, D_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("d_pc",    D_PC,    sb[0].pc);
      chk("d_instr", D_Instr, sb[0].instr);
      chk("d_exc",   {29'd0, D_exc}, {29'd0, sb[0].exc});
    end else begin
      chk("d_zero", D_PC | D_Instr | {29'd0, D_exc}, 32'd0);
    end
    m_enq = v && (sb.size() < DEPTH) && !fl;
    m_deq = (sb.size() != 0) && rd && !fl;
    @(posedge Clk);
    #1;
    if (fl) sb.delete();
    else begin
      if (m_deq) begin void'(sb.pop_front()); n_pop++; end
      if (m_enq) begin e.pc = pc; e.instr = ins; e.exc = ex; sb.push_back(e); end
    end
    chk("q_count", {29'd0, q_count}, sb.size());
    chk("q_full",  {31'd0, q_full},  {31'd0, sb.size() == DEPTH});
    chk("q_afull", {31'd0, q_almost_full}, {31'd0, sb.size() >= DEPTH - 1});
    if (exp_count >= 0) begin
      chk("tbl_count", {29'd0, q_count}, exp_count);
      chk("tbl_full",  {31'd0, q_full},  {31'd0, exp_full});
      chk("tbl_afull", {31'd0, q_almost_full}, {31'd0, exp_afull});
    end
  endtask

  vec_t tbl [16];

  initial begin
    // Single entry, then fill/stall/drain, then flush.
    tbl[0]  = '{1'b0, 1'b1, 32'hBFC00000, 32'h24020001, 3'b000, 1'b0, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b000, 1'b1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h00001000, 32'hA0000001, 3'b000, 1'b0, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h00001004, 32'hA0000002, 3'b001, 1'b0, 2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h00001008, 32'hA0000003, 3'b000, 1'b0, 3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000100C, 32'hA0000004, 3'b010, 1'b0, 4, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h00001010, 32'hA0000005, 3'b000, 1'b0, 4, 1'b1, 1'b1};
    // Full: enqueue ignored even while a dequeue happens.
    tbl[7]  = '{1'b0, 1'b1, 32'h00001014, 32'hA0000006, 3'b000, 1'b1, 3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b000, 1'b1, 2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b000, 1'b1, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b000, 1'b1, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h00002000, 32'hB0000001, 3'b000, 1'b0, 1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'h00002004, 32'hB0000002, 3'b000, 1'b0, 2, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h00002008, 32'hB0000003, 3'b000, 1'b0, 3, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'hDEAD0000, 32'hDEADBEEF, 3'b000, 1'b1, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        3'b000, 1'b1, 0, 1'b0, 1'b0};

    Clr_n = 1'b0; flush = 1'b0; I_valid = 1'b0; I_PC = '0; I_Instr = '0;
    I_exc = '0; D_ready = 1'b0;
    #12;
    chk("rst_count", {29'd0, q_count}, 32'd0);
    chk("rst_valid", {31'd0, D_valid}, 32'd0);
    chk("rst_full",  {30'd0, q_full, q_almost_full}, 32'd0);
    @(posedge Clk); #1;
    Clr_n = 1'b1;

    for (int i = 0; i < 16; i++)
      step(tbl[i].flush, tbl[i].valid, tbl[i].pc, tbl[i].instr, tbl[i].exc,
           tbl[i].ready, tbl[i].exp_count, tbl[i].exp_full, tbl[i].exp_afull);

    // Steady stream: 10 entries with decode always ready.
    n_pop = 0;
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 32'h00003000 + 32'(i * 4), 32'hC0000000 + 32'(i), 3'b000, 1'b1,
           1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 0, 1'b0, 1'b0);
    chk("stream_pops", n_pop, 32'd10);

    // Wrap with one exception-carrying entry.
    n_pop = 0;
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 32'h00004000 + 32'(i * 4), 32'hD0000000 + 32'(i),
           (i == 4) ? 3'b100 : 3'b000, (i >= 2), -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, -1, 1'b0, 1'b0);
    chk("wrap_pops", n_pop, 32'd7);

    // Asynchronous reset between edges with two entries queued.
    step(1'b0, 1'b1, 32'h00005000, 32'hE0000001, 3'b000, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h00005004, 32'hE0000002, 3'b000, 1'b0, 2, 1'b0, 1'b0);
    I_valid = 1'b0;
    #2;
    Clr_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, D_valid}, 32'd0);
    chk("arst_count", {29'd0, q_count}, 32'd0);
    chk("arst_pc",    D_PC, 32'd0);
    sb.delete();
    @(posedge Clk); #1;
    Clr_n = 1'b1;
    step(1'b0, 1'b1, 32'h00006000, 32'hF0000001, 3'b011, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Clr_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port flush  input  1  synchronous discard of all queued entries (exception or redirect).
REQ-005 The block SHALL have port I_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 The block SHALL have port I_PC  input  32  PC of the presented instruction.
REQ-007 The block SHALL have port I_Instr  input  32  instruction word.
REQ-008 The block SHALL have port I_exc  input  3  {miss, illegal, invalid} fetch exception flags.
REQ-009 The block SHALL have port q_full  output  1  high when count equals DEPTH; fetch must stall.
REQ-010 The block SHALL have port q_almost_full  output  1  high when count is at least DEPTH-1.
REQ-011 The block SHALL have port D_ready  input  1  decode accepts the head entry this cycle.
REQ-012 The block SHALL have port D_valid  output  1  head entry is valid.
REQ-013 The block SHALL have ports D_PC  output  32, D_Instr  output  32 and D_exc  output  3, which are the head entry fields.
REQ-014 The block SHALL have port q_count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 The block SHALL store entries in a circular buffer with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Enqueue SHALL occur when I_valid=1, q_full=0 and flush=0; the input is written at the write pointer and the pointer advances.
REQ-017 I_valid=1 with q_full=1 SHALL be ignored, even if a dequeue occurs in the same cycle.
REQ-018 Dequeue SHALL occur when D_valid=1, D_ready=1 and flush=0; the read pointer advances.
REQ-019 Simultaneous enqueue and dequeue SHALL leave q_count unchanged; enqueue only increments it by 1; dequeue only decrements it by 1.
REQ-020 D_valid SHALL equal (q_count != 0) when bypass is absent.
REQ-021 When D_valid=0, D_PC, D_Instr and D_exc SHALL be driven as 0.
REQ-022 Without bypass, an entry enqueued at edge N SHALL appear at the head in the cycle following N, giving one cycle of latency.
REQ-023 flush SHALL take priority over enqueue and dequeue; at the next edge both pointers and q_count are 0 and the enqueue in the flush cycle is discarded.
REQ-024 Order SHALL be strictly FIFO; I_exc flags SHALL travel with their entry unmodified.
REQ-025 q_full and q_almost_full SHALL be combinational from q_count only.

Reset
REQ-026 Asserting Clr_n=0 SHALL immediately clear the pointers and q_count to 0, force D_valid=0, and drive D_PC, D_Instr and D_exc to 0, regardless of Clk.
REQ-027 Entry storage need not be cleared by reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion accepts an enqueue normally.

Configuration
REQ-029 Macro IFQ_BYPASS_EN SHALL, when defined, make an empty queue with I_valid=1 and flush=0 drive D_valid=1 and D_PC, D_Instr and D_exc directly from the inputs in the same cycle.
REQ-030 With IFQ_BYPASS_EN defined, if D_ready=1 in a bypass cycle the entry is consumed and not written; if D_ready=0 it is enqueued normally.
REQ-031 Without IFQ_BYPASS_EN, no combinational path from I_* to D_* SHALL exist, and the REQ-022 latency applies.

Verification
REQ-032 Reset and single entry: after reset, hold D_ready=0 and enqueue PC=0xBFC00000, Instr=0x24020001 -> next cycle D_valid=1 with those values and q_count=1.
REQ-033 Fill and stall: with DEPTH=4 and D_ready=0, enqueue 5 entries -> q_almost_full at count 3, q_full at count 4, the 5th entry is dropped, and draining returns exactly entries 1-4 in order.
REQ-034 Steady stream: with D_ready=1 and I_valid=1 for 10 cycles, q_count stays at 1 (no bypass) or 0 (bypass), and all 10 PCs emerge in order.
REQ-035 Flush: with 3 entries queued, assert flush together with I_valid -> next cycle q_count=0 and D_valid=0, and the flushed-cycle PC never appears.
REQ-036 Wrap and exceptions: enqueue and dequeue 7 entries through DEPTH=4, one carrying I_exc=3'b100 -> correct order across the wrap, and D_exc=3'b100 only on that entry.
REQ-037 Async reset: assert Clr_n=0 between edges with 2 entries queued -> D_valid drops before the next edge, and q_count=0.
